// File: rtl/pdm_modulator.sv
// 8-bit PCM to 1-bit PDM transmitter: sample FIFO with a synchronised write
// strobe, bit-clock divider and a second-order saturating sigma-delta loop.
module pdm_modulator #(
  parameter int CLK_DIV    = 4,
  parameter int OSR        = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int OW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [OW-1:0] OSR_LAST  = OW'(OSR - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  function automatic logic signed [17:0] ext16(input logic signed [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

  function automatic logic signed [17:0] ext8(input logic signed [7:0] v);
    return {{10{v[7]}}, v};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7fff;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // sync_q[0], sync_q[1] form the synchroniser; sync_q[2] is the edge register
  logic [2:0]             sync_q, sync_d;
  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic [OW-1:0]          osr_cnt_q, osr_cnt_d;
  logic                   pdm_clk_q, pdm_clk_d;
  logic                   pdm_out_q, pdm_out_d;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [7:0]             mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic signed [7:0]      x_q, x_d;
  logic                   primed_q, primed_d;
  logic signed [15:0]     i1_q, i1_d;
  logic signed [15:0]     i2_q, i2_d;
  logic                   underrun_q, underrun_d;
  logic                   overflow_q, overflow_d;

  logic                   strobe_rise;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   tick;
  logic                   fetch;
  logic                   pop;
  logic                   push_req;
  logic                   push;
  logic signed [7:0]      x_eff;
  logic                   y;
  logic signed [15:0]     fb;
  logic signed [17:0]     i1_sum;
  logic signed [17:0]     i2_sum;
  logic signed [15:0]     i1_new;
  logic signed [15:0]     i2_new;

  always_comb begin
    sync_d      = {sync_q[1:0], uio_in[0]};
    strobe_rise = sync_q[1] & ~sync_q[2];

    fifo_full  = (count_q == FIFO_FULL);
    fifo_empty = (count_q == '0);

    tick     = ena && (div_cnt_q == '0);
    fetch    = tick && (osr_cnt_q == '0);
    pop      = fetch && !fifo_empty;
    push_req = ena && strobe_rise;
    // a pop in the same cycle frees a slot, so a push into a full FIFO is kept
    push     = push_req && (!fifo_full || pop);

    div_cnt_d = div_cnt_q;
    if (ena) div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);

    osr_cnt_d = osr_cnt_q;
    if (tick) osr_cnt_d = (osr_cnt_q == OSR_LAST) ? '0 : osr_cnt_q + OW'(1);

    pdm_clk_d = pdm_clk_q;
    if (tick)                              pdm_clk_d = 1'b1;
    else if (ena && div_cnt_q == DIV_HALF) pdm_clk_d = 1'b0;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = ui_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    // the sample fetched on this tick already drives this tick's loop update
    x_eff    = pop ? $signed(mem_q[rd_ptr_q]) : x_q;
    x_d      = x_eff;
    primed_d = primed_q | pop;

    y      = ~i2_q[15];
    fb     = y ? 16'sd128 : -16'sd128;
    i1_sum = ext16(i1_q) + ext8(x_eff) - ext16(fb);
    i1_new = sat16(i1_sum);
    i2_sum = ext16(i2_q) + ext16(i1_new) - ext16(fb);
    i2_new = sat16(i2_sum);

    pdm_out_d = pdm_out_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    if (tick) begin
      pdm_out_d = y;
      i1_d      = i1_new;
      i2_d      = i2_new;
    end

    // set events are applied after the clear so they win a same-cycle clash
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (uio_in[1]) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (fetch && fifo_empty && primed_q) underrun_d = 1'b1;
    if (push_req && !push)               overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      div_cnt_q  <= '0;
      osr_cnt_q  <= '0;
      pdm_clk_q  <= 1'b0;
      pdm_out_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      x_q        <= '0;
      primed_q   <= 1'b0;
      i1_q       <= '0;
      i2_q       <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      div_cnt_q  <= div_cnt_d;
      osr_cnt_q  <= osr_cnt_d;
      pdm_clk_q  <= pdm_clk_d;
      pdm_out_q  <= pdm_out_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      x_q        <= x_d;
      primed_q   <= primed_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign uo_out  = {1'b0, ~fifo_full, overflow_q, underrun_q,
                    fifo_empty, fifo_full, pdm_clk_q, pdm_out_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:2]};

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: a reference sigma-delta model consumes a
// queue of written samples and checks every PDM bit plus flags and densities.
module tb_pdm_modulator;
  localparam int CLK_DIV    = 4;
  localparam int OSR        = 32;
  localparam int FIFO_DEPTH = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       ena    = 1'b0;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  pdm_modulator #(
    .CLK_DIV    (CLK_DIV),
    .OSR        (OSR),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  int   cyc = 0;
  int   ticks = 0;
  int   ones = 0;
  int   m_osr = 0;
  int   m_x = 0;
  int   m_i1 = 0;
  int   m_i2 = 0;
  bit   m_primed = 1'b0;
  bit   prev_clk = 1'b0;
  int   last_fetch = 0;
  int   ones_hist [0:1023];
  logic [7:0] exp_q [$];
  int   stamp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_tick();
    logic [7:0] smp;
    int y;
    int fb;
    if (m_osr == 0) begin
      last_fetch = cyc;
      if (exp_q.size() > 0 && stamp_q[0] < cyc) begin
        smp = exp_q.pop_front();
        stamp_q.delete(0);
        m_x = $signed(smp);
        m_primed = 1'b1;
      end else begin
        check("fetch_underrun", {31'b0, uo_out[4]}, {31'b0, m_primed});
      end
    end
    y = (m_i2 >= 0) ? 1 : 0;
    check("pdm_bit", {31'b0, uo_out[0]}, y);
    fb = (y == 1) ? 128 : -128;
    m_i1 = sat(m_i1 + m_x - fb);
    m_i2 = sat(m_i2 + m_i1 - fb);
    m_osr = (m_osr + 1) % OSR;
    ticks++;
    ones += y;
    if (ticks < 1024) ones_hist[ticks] = ones;
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst_n) begin
      cyc = 0; ticks = 0; ones = 0; m_osr = 0; m_x = 0; m_i1 = 0; m_i2 = 0;
      m_primed = 1'b0; prev_clk = 1'b0;
      exp_q.delete(); stamp_q.delete();
      ones_hist[0] = 0;
    end else begin
      cyc++;
      if (uo_out[1] && !prev_clk) model_tick();
      prev_clk = uo_out[1];
    end
  endtask

  task automatic do_reset();
    uio_in = 8'h00;
    ena    = 1'b1;
    ui_in  = 8'($urandom_range(0, 255));
    rst_n  = 1'b0;
    #1;
    check("reset_uo", {24'b0, uo_out}, 32'h48);
    check("reset_uio_oe", {24'b0, uio_oe}, 32'h0);
    check("reset_uio_out", {24'b0, uio_out}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("release_uo", {24'b0, uo_out}, 32'h48);
  endtask

  // the DUT pushes on the third rising clk edge after the strobe rises
  task automatic write_sample(input logic [7:0] v, input bit keep);
    uio_in[0] = 1'b1;
    ui_in     = v;
    if (keep) begin
      exp_q.push_back(v);
      stamp_q.push_back(cyc + 3);
    end
    repeat (3) step();
    uio_in[0] = 1'b0;
    repeat (2) step();
  endtask

  task automatic run_until(input int target);
    int g = 0;
    while (ticks < target && g < 5000) begin
      step();
      g++;
    end
    check("run_timeout", {31'b0, ticks >= target}, 32'h1);
  endtask

  task automatic feed_until(input logic [7:0] v, input int target);
    int g = 0;
    while (ticks < target && g < 4000) begin
      if (!uo_out[2]) write_sample(v, 1'b1);
      else            step();
      g++;
    end
    check("feed_timeout", {31'b0, ticks >= target}, 32'h1);
  endtask

  initial begin
    logic [4:0] clk_pat;
    logic [7:0] dens_x   [3];
    int         dens_exp [3];
    logic [7:0] vals     [4];
    int         win_exp  [4];
    logic [1:0] frz;
    int         nf;
    int         g;

    // reset state and pdm_clk shape after release
    #2;
    do_reset();
    clk_pat = 5'b10011;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) check("first_tick_uo", {24'b0, uo_out}, 32'h4B);
      check("pdm_clk_shape", {31'b0, uo_out[1]}, {31'b0, clk_pat[i]});
    end

    // ones density with a continuously fed constant sample
    dens_x[0] = 8'h00; dens_exp[0] = 128;
    dens_x[1] = 8'h60; dens_exp[1] = 224;
    dens_x[2] = 8'hA0; dens_exp[2] = 32;
    for (int k = 0; k < 3; k++) begin
      #2;
      do_reset();
      feed_until(dens_x[k], 288);
      check_range("density256", ones_hist[288] - ones_hist[32], dens_exp[k] - 4, dens_exp[k] + 4);
      check("dens_no_overflow", {31'b0, uo_out[5]}, 32'h0);
      check("dens_no_underrun", {31'b0, uo_out[4]}, 32'h0);
    end

    // fill to full, overflow on a fifth write, drain into underrun
    #2;
    do_reset();
    vals[0] = 8'hC0; win_exp[0] = 8;
    vals[1] = 8'h20; win_exp[1] = 20;
    vals[2] = 8'h60; win_exp[2] = 28;
    vals[3] = 8'h00; win_exp[3] = 16;
    for (int i = 0; i < 4; i++) write_sample(vals[i], 1'b1);
    check("full_after_4", {31'b0, uo_out[2]}, 32'h1);
    check("sample_req_full", {31'b0, uo_out[6]}, 32'h0);
    check("overflow_before_5th", {31'b0, uo_out[5]}, 32'h0);
    write_sample(8'h80, 1'b0);
    check("overflow_after_5th", {31'b0, uo_out[5]}, 32'h1);
    check("full_after_5th", {31'b0, uo_out[2]}, 32'h1);
    run_until(192);
    for (int i = 0; i < 4; i++) begin
      check_range("window_density", ones_hist[64 + 32 * i] - ones_hist[32 + 32 * i],
                  win_exp[i] - 4, win_exp[i] + 4);
    end
    check_range("held_x_density", ones_hist[192] - ones_hist[160], 12, 20);
    check("underrun_after_drain", {31'b0, uo_out[4]}, 32'h1);
    check("empty_after_drain", {31'b0, uo_out[3]}, 32'h1);

    // clear flags, then a clear that lands on an underrun tick
    uio_in[1] = 1'b1;
    step();
    uio_in[1] = 1'b0;
    check("clr_underrun", {31'b0, uo_out[4]}, 32'h0);
    check("clr_overflow", {31'b0, uo_out[5]}, 32'h0);
    nf = last_fetch + OSR * CLK_DIV;
    g = 0;
    while (cyc < nf - 1 && g < 500) begin
      step();
      g++;
    end
    uio_in[1] = 1'b1;
    step();
    uio_in[1] = 1'b0;
    check("clr_vs_set", {31'b0, uo_out[4]}, 32'h1);
    step();
    check("clr_vs_set_hold", {31'b0, uo_out[4]}, 32'h1);

    // freeze with ena low mid-sample; a strobe while frozen is ignored
    write_sample(8'h40, 1'b1);
    run_until(240);
    ena = 1'b0;
    frz = uo_out[1:0];
    write_sample(8'h7F, 1'b0);
    check("ena_freeze", {30'b0, uo_out[1:0]}, {30'b0, frz});
    repeat (5) begin
      step();
      check("ena_freeze", {30'b0, uo_out[1:0]}, {30'b0, frz});
    end
    ena = 1'b1;
    run_until(322);
    check_range("resume_density", ones_hist[256] - ones_hist[224], 20, 28);
    check("ena_strobe_ignored", {31'b0, uo_out[3]}, 32'h1);

    // asynchronous reset with two samples queued
    write_sample(8'h50, 1'b1);
    write_sample(8'hB0, 1'b1);
    check("two_queued_not_empty", {31'b0, uo_out[3]}, 32'h0);
    step();
    #2;
    do_reset();
    run_until(40);
    check("post_reset_no_underrun", {31'b0, uo_out[4]}, 32'h0);
    check("post_reset_empty", {31'b0, uo_out[3]}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_modulator.md
Name: pdm_modulator

Overview:
Transmit-side counterpart of the decimation filter. Accepts 8-bit signed PCM samples through a small FIFO and produces a 1-bit PDM bitstream with a bit clock. The bitstream comes from a second-order sigma-delta modulator at OSR bits per sample. It is a Tiny Tapeout user project, and its output can feed the decimation filter directly for loopback.

Parameters:
CLK_DIV, 4, clk cycles per PDM bit; even, >=2
OSR, 32, PDM bits per PCM sample; power of two, 4..256
FIFO_DEPTH, 4, sample FIFO entries; power of two, 2..16

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  design enable; low freezes the divider, modulator and FIFO writes
ui_in  in  8  PCM sample, two's complement
uio_in  in  8  [0]=wr_strobe (async, rising edge writes), [1]=clr_flags (sync level), [7:2] unused
uio_out  out  8  always 0
uio_oe  out  8  always 0 (all uio are inputs)
uo_out  out  8  [0]=pdm_out [1]=pdm_clk [2]=fifo_full [3]=fifo_empty [4]=underrun [5]=overflow [6]=sample_req [7]=0

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count = 0, integrators I1 = I2 = 0, x = 0, div_cnt = osr_cnt = 0, primed = 0, synchronizer flops = 0.
  - Resulting uo_out = 8'b0100_1000 (empty=1, sample_req=1, all else 0).
  - Reset mid-stream discards FIFO contents and modulator state immediately.
- Write path:
  - wr_strobe passes through a 2-flop synchronizer plus an edge register.
  - A rising edge is detected 2 clk after the first clk edge that samples it high.
  - On the detect cycle (ena=1), ui_in is pushed. ui_in must be stable from strobe rise until 3 clk after.
  - Push while full: sample dropped, overflow set.
- Bit tick: div_cnt counts 0..CLK_DIV-1 while ena=1. A tick occurs on an enabled cycle with div_cnt==0, so the first tick is on the first enabled cycle after reset.
- pdm_clk (registered): goes 1 on the tick edge, returns 0 exactly CLK_DIV/2 clk later. pdm_out changes only on pdm_clk rising edges; receivers sample on the falling edge.
- Sample fetch: on a tick with osr_cnt==0:
  - FIFO non-empty: pop head into x, set primed.
  - FIFO empty: x holds its previous value; underrun is set only if primed=1.
  - osr_cnt increments mod OSR on every tick.
- Modulator, per tick, in this order (all arithmetic 16-bit signed, saturating to [-32768, 32767]):
  1. y = (I2 >= 0); pdm_out <= y.
  2. fb = y ? +128 : -128.
  3. I1' = sat(I1 + sext(x) - fb).
  4. I2' = sat(I2 + I1' - fb); I1 <= I1', I2 <= I2'.
  - Expected ones density ≈ (x+128)/256.
- FIFO: count in 0..FIFO_DEPTH.
  - Push and pop in the same cycle with count>0: both occur, count unchanged.
  - Push and pop in the same cycle with count==0: pop sees empty (no bypass), push is stored.
  - fifo_full = (count==FIFO_DEPTH); fifo_empty = (count==0); sample_req = !fifo_full. All registered-state derived, no combinational path from inputs.
- Sticky flags (underrun, overflow): clr_flags=1 clears both on the next edge. A set event in the same cycle wins.
- ena=0: all counters, integrators, pdm_clk and pdm_out hold. Detected strobe edges are ignored; the synchronizer keeps running.

Test Plan:
1. Reset with ena=1, ui_in random -> uo_out=8'h48 while rst_n=0 and on the first cycle after release; uio_oe=0, uio_out=0.
2. Push x=0 continuously, CLK_DIV=4, OSR=32; count ones over 256 pdm_clk rising edges -> 128±4. Repeat with x=+96 -> 224±4; x=-96 -> 32±4. pdm_clk period = 4 clk, high 2 clk.
3. Strobe 4 samples back-to-back before the first fetch -> fifo_full=1 and sample_req=0 after the 4th detect. A 5th strobe sets overflow=1; the 5th sample is not heard (density checks match the first four values in order).
4. Push one sample, let the FIFO drain past the next fetch tick -> underrun=1 at that tick and x held (density unchanged). Pulse clr_flags -> underrun=0 next cycle. Clear coinciding with an underrun tick -> underrun stays 1.
5. Drop ena for 10 cycles mid-sample -> pdm_out and pdm_clk frozen, integrators unchanged. Resume -> bit sequence continues identically to an uninterrupted reference model.
6. Assert rst_n low mid-stream with 2 samples queued -> outputs = 8'h48 asynchronously. After release, FIFO is empty and the first fetch does not set underrun (primed=0).
